// File: rtl/alu_control_md_pkg.sv
// Shared constants for the ALU control unit with mul/div sequencer:
// ALUOp classes, funct codes, ALU/HI-LO operation codes and FSM states.
package alu_control_md_pkg;

    // Operation classes driven by the main Control unit
    localparam logic [2:0] ALUOP_LUI    = 3'b000;
    localparam logic [2:0] ALUOP_ORI    = 3'b001;
    localparam logic [2:0] ALUOP_ADDI   = 3'b010;
    localparam logic [2:0] ALUOP_MEM    = 3'b011;
    localparam logic [2:0] ALUOP_BRANCH = 3'b100;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b111;

    // R-type funct field values
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;

    // ALU / HI-LO operation codes
    typedef enum logic [3:0] {
        CTRL_AND  = 4'b0000,
        CTRL_OR   = 4'b0001,
        CTRL_NOR  = 4'b0010,
        CTRL_ADD  = 4'b0011,
        CTRL_SUB  = 4'b0100,
        CTRL_LUI  = 4'b0101,
        CTRL_SLL  = 4'b0110,
        CTRL_SRL  = 4'b0111,
        CTRL_JR   = 4'b1000,
        CTRL_NONE = 4'b1001,
        CTRL_MULT = 4'b1010,
        CTRL_DIV  = 4'b1011,
        CTRL_MFHI = 4'b1100,
        CTRL_MFLO = 4'b1101
    } ctrl_e;

    // Mul/div sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/alu_control_md_if.sv
// Decode-side bus of the ALU control unit: instruction fields in,
// operation code and mul/div strobes out.
interface alu_control_md_if #(
    parameter int ALUOP_WIDTH = 3,
    parameter int CTRL_WIDTH  = 4
);
    logic                   Valid;
    logic [ALUOP_WIDTH-1:0] ALUOp;
    logic [5:0]             ALUFunction;
    logic [CTRL_WIDTH-1:0]  ALUOperation;
    logic                   MDStart;
    logic                   MDStep;
    logic                   MDSigned;
    logic                   MDDiv;
    logic                   HILOWrite;
    logic                   Stall;
    logic                   Busy;

    // Control / pipeline side
    modport master (
        output Valid, ALUOp, ALUFunction,
        input  ALUOperation, MDStart, MDStep, MDSigned, MDDiv,
               HILOWrite, Stall, Busy
    );

    // ALU control unit side
    modport slave (
        input  Valid, ALUOp, ALUFunction,
        output ALUOperation, MDStart, MDStep, MDSigned, MDDiv,
               HILOWrite, Stall, Busy
    );
endinterface

// File: rtl/alu_control_md_sequencer.sv
// Iterative mul/div sequencer: IDLE -> RUN (DATA_WIDTH steps) -> DONE.
// Owns the step counter and the signed/divide flags latched at start.
module alu_md_sequencer
    import alu_control_md_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      start_req,
    input  logic      req_signed,
    input  logic      req_div,
    output logic      md_start,
    output logic      md_step,
    output logic      hilo_write,
    output logic      stall,
    output logic      busy,
    output logic      md_signed,
    output logic      md_div,
    output md_state_e state
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             signed_reg, signed_next;
    logic             div_reg, div_next;

    // State, counter and latched flags; active-low reset returns to IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            signed_reg <= 1'b0;
            div_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            signed_reg <= signed_next;
            div_reg    <= div_next;
        end
    end

    // Next state and strobes; all strobes forced low while reset is held
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        signed_next = signed_reg;
        div_next    = div_reg;
        md_start    = 1'b0;
        md_step     = 1'b0;
        hilo_write  = 1'b0;
        stall       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    md_start    = 1'b1;
                    stall       = 1'b1;
                    signed_next = req_signed;
                    div_next    = req_div;
                    cnt_next    = '0;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                md_step = 1'b1;
                stall   = 1'b1;
                // Hold the counter on the final step so it never wraps
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Instruction retires here; decode input deliberately ignored
                hilo_write = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (!reset) begin
            md_start   = 1'b0;
            md_step    = 1'b0;
            hilo_write = 1'b0;
            stall      = 1'b0;
        end
    end

    assign busy      = reset && (state_reg != ST_IDLE);
    assign md_signed = reset && signed_reg;
    assign md_div    = reset && div_reg;
    assign state     = state_reg;

endmodule

// File: rtl/alu_control_md.sv
// ALU control unit: combinational {ALUOp, funct} decode plus an
// iterative mul/div sequencer that stalls the pipeline while it runs.
module alu_control_md
    import alu_control_md_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 3,
    parameter int CTRL_WIDTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_control_md_if.slave   bus
);

    localparam logic [ALUOP_WIDTH-1:0] OP_LUI    = ALUOP_WIDTH'(ALUOP_LUI);
    localparam logic [ALUOP_WIDTH-1:0] OP_ORI    = ALUOP_WIDTH'(ALUOP_ORI);
    localparam logic [ALUOP_WIDTH-1:0] OP_ADDI   = ALUOP_WIDTH'(ALUOP_ADDI);
    localparam logic [ALUOP_WIDTH-1:0] OP_MEM    = ALUOP_WIDTH'(ALUOP_MEM);
    localparam logic [ALUOP_WIDTH-1:0] OP_BRANCH = ALUOP_WIDTH'(ALUOP_BRANCH);
    localparam logic [ALUOP_WIDTH-1:0] OP_RTYPE  = ALUOP_WIDTH'(ALUOP_RTYPE);

    logic      valid_eff;
    logic      md_req;
    ctrl_e     dec_code;
    ctrl_e     op_code;
    md_state_e seq_state;

    // Valid is treated as 0 while reset is held
    assign valid_eff = bus.Valid && reset;
    // MULT/MULTU/DIV/DIVU share funct prefix 0110; bit0 = unsigned, bit1 = divide
    assign md_req    = valid_eff && (bus.ALUOp == OP_RTYPE)
                       && (bus.ALUFunction[5:2] == F_MULT[5:2]);

    // Single-cycle decode of the operation class and funct field
    always_comb begin
        dec_code = CTRL_NONE;
        if (valid_eff) begin
            casez ({bus.ALUOp, bus.ALUFunction})
                {OP_LUI,    6'b??????}: dec_code = CTRL_LUI;
                {OP_ORI,    6'b??????}: dec_code = CTRL_OR;
                {OP_ADDI,   6'b??????},
                {OP_MEM,    6'b??????}: dec_code = CTRL_ADD;
                {OP_BRANCH, 6'b??????}: dec_code = CTRL_SUB;
                {OP_RTYPE,  F_AND}:     dec_code = CTRL_AND;
                {OP_RTYPE,  F_OR}:      dec_code = CTRL_OR;
                {OP_RTYPE,  F_NOR}:     dec_code = CTRL_NOR;
                {OP_RTYPE,  F_ADD}:     dec_code = CTRL_ADD;
                {OP_RTYPE,  F_SUB}:     dec_code = CTRL_SUB;
                {OP_RTYPE,  F_SLL}:     dec_code = CTRL_SLL;
                {OP_RTYPE,  F_SRL}:     dec_code = CTRL_SRL;
                {OP_RTYPE,  F_JR}:      dec_code = CTRL_JR;
                {OP_RTYPE,  F_MFHI}:    dec_code = CTRL_MFHI;
                {OP_RTYPE,  F_MFLO}:    dec_code = CTRL_MFLO;
                {OP_RTYPE,  F_MULT},
                {OP_RTYPE,  F_MULTU}:   dec_code = CTRL_MULT;
                {OP_RTYPE,  F_DIV},
                {OP_RTYPE,  F_DIVU}:    dec_code = CTRL_DIV;
                default:                dec_code = CTRL_NONE;
            endcase
        end
    end

    alu_md_sequencer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .start_req  (md_req),
        .req_signed (~bus.ALUFunction[0]),
        .req_div    (bus.ALUFunction[1]),
        .md_start   (bus.MDStart),
        .md_step    (bus.MDStep),
        .hilo_write (bus.HILOWrite),
        .stall      (bus.Stall),
        .busy       (bus.Busy),
        .md_signed  (bus.MDSigned),
        .md_div     (bus.MDDiv),
        .state      (seq_state)
    );

    // Outside IDLE the latched mul/div code overrides the live decode
    always_comb begin
        op_code = dec_code;
        if (reset && (seq_state != ST_IDLE)) begin
            op_code = bus.MDDiv ? CTRL_DIV : CTRL_MULT;
        end
    end

    assign bus.ALUOperation = CTRL_WIDTH'(op_code);

endmodule

// File: tb/tb_alu_control_md.sv
// Self-checking bench for alu_control_md: directed checks with literal
// expectations, then randomized stimulus against a cycle-count model.
module tb_alu_control_md;

    localparam int DW = 32;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    alu_control_md_if #(.ALUOP_WIDTH(3), .CTRL_WIDTH(4)) bus ();

    alu_control_md #(
        .DATA_WIDTH  (DW),
        .ALUOP_WIDTH (3),
        .CTRL_WIDTH  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Reference decode table: operation code for a decode-cycle instruction
    function automatic logic [3:0] ref_decode(input logic v, input logic [2:0] op,
                                              input logic [5:0] f);
        if (!v) return 4'b1001;
        case (op)
            3'b000:         return 4'b0101;
            3'b001:         return 4'b0001;
            3'b010, 3'b011: return 4'b0011;
            3'b100:         return 4'b0100;
            3'b111: begin
                case (f)
                    6'b100100: return 4'b0000;
                    6'b100101: return 4'b0001;
                    6'b100111: return 4'b0010;
                    6'b100000: return 4'b0011;
                    6'b100010: return 4'b0100;
                    6'b000000: return 4'b0110;
                    6'b000010: return 4'b0111;
                    6'b001000: return 4'b1000;
                    6'b010000: return 4'b1100;
                    6'b010010: return 4'b1101;
                    6'b011000, 6'b011001: return 4'b1010;
                    6'b011010, 6'b011011: return 4'b1011;
                    default:   return 4'b1001;
                endcase
            end
            default: return 4'b1001;
        endcase
    endfunction

    function automatic bit is_md(input logic v, input logic [2:0] op, input logic [5:0] f);
        return v && (op == 3'b111) &&
               (f == 6'b011000 || f == 6'b011001 || f == 6'b011010 || f == 6'b011011);
    endfunction

    // Model: m_cyc counts cycles since the MDStart cycle (0 = no op in flight)
    int   m_cyc = 0;
    logic m_sgn = 1'b0;
    logic m_div = 1'b0;

    // Per-cycle compare against the model, then advance the model
    initial begin
        logic [3:0] e_op;
        logic e_start, e_step, e_hilo, e_stall, e_busy;
        forever begin
            @(negedge clk);
            e_op = 4'b1001; e_start = 0; e_step = 0; e_hilo = 0; e_stall = 0; e_busy = 0;
            if (reset === 1'b1) begin
                if (m_cyc == 0) begin
                    e_op = ref_decode(bus.Valid, bus.ALUOp, bus.ALUFunction);
                    if (is_md(bus.Valid, bus.ALUOp, bus.ALUFunction)) begin
                        e_start = 1; e_stall = 1;
                    end
                end else begin
                    e_busy = 1;
                    e_op   = m_div ? 4'b1011 : 4'b1010;
                    if (m_cyc <= DW) begin
                        e_step = 1; e_stall = 1;
                    end else begin
                        e_hilo = 1;
                    end
                end
            end
            check("ALUOperation", int'(bus.ALUOperation), int'(e_op));
            check("MDStart",   int'(bus.MDStart),   int'(e_start));
            check("MDStep",    int'(bus.MDStep),    int'(e_step));
            check("HILOWrite", int'(bus.HILOWrite), int'(e_hilo));
            check("Stall",     int'(bus.Stall),     int'(e_stall));
            check("Busy",      int'(bus.Busy),      int'(e_busy));
            check("MDSigned",  int'(bus.MDSigned),  int'(reset && m_sgn));
            check("MDDiv",     int'(bus.MDDiv),     int'(reset && m_div));
            if (reset !== 1'b1) begin
                m_cyc = 0; m_sgn = 0; m_div = 0;
            end else if (m_cyc == 0) begin
                if (e_start) begin
                    m_cyc = 1;
                    m_sgn = (bus.ALUFunction == 6'b011000 || bus.ALUFunction == 6'b011010);
                    m_div = (bus.ALUFunction == 6'b011010 || bus.ALUFunction == 6'b011011);
                end
            end else if (m_cyc == DW + 1) begin
                m_cyc = 0;
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f);
        bus.Valid = v; bus.ALUOp = op; bus.ALUFunction = f;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold one mul/div instruction for DW+2 cycles and tally its strobes
    task automatic run_md(input logic [5:0] f, output int starts, output int steps,
                          output int stalls, output int hilos, output int start_cyc,
                          output int hilo_cyc, output logic sgn, output logic dv);
        starts = 0; steps = 0; stalls = 0; hilos = 0;
        start_cyc = -1; hilo_cyc = -1; sgn = 1'bx; dv = 1'bx;
        drive(1'b1, 3'b111, f);
        for (int c = 0; c < DW + 2; c++) begin
            @(negedge clk);
            if (bus.MDStart)   begin starts++; start_cyc = c; end
            if (bus.MDStep)    steps++;
            if (bus.Stall)     stalls++;
            if (bus.HILOWrite) begin hilos++; hilo_cyc = c; sgn = bus.MDSigned; dv = bus.MDDiv; end
            next_cycle();
        end
    endtask

    initial begin
        logic [12:0] vec [17];
        int   st, sp, sl, hw, sc, hc;
        logic sg, dv;
        logic [12:0] e;

        reset = 1'b0;
        drive(1'b0, 3'b000, 6'b000000);
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_ALUOperation", int'(bus.ALUOperation), 9);
        check("rst_Busy",  int'(bus.Busy),  0);
        check("rst_Stall", int'(bus.Stall), 0);
        reset = 1'b1;
        next_cycle();

        // Legacy and new decode: {ALUOp, funct, expected code}
        vec[0]  = {3'b111, 6'b100100, 4'b0000};
        vec[1]  = {3'b111, 6'b100101, 4'b0001};
        vec[2]  = {3'b001, 6'b010101, 4'b0001};
        vec[3]  = {3'b111, 6'b100111, 4'b0010};
        vec[4]  = {3'b111, 6'b100000, 4'b0011};
        vec[5]  = {3'b010, 6'b111000, 4'b0011};
        vec[6]  = {3'b011, 6'b000001, 4'b0011};
        vec[7]  = {3'b111, 6'b100010, 4'b0100};
        vec[8]  = {3'b100, 6'b000000, 4'b0100};
        vec[9]  = {3'b000, 6'b101010, 4'b0101};
        vec[10] = {3'b111, 6'b000000, 4'b0110};
        vec[11] = {3'b111, 6'b000010, 4'b0111};
        vec[12] = {3'b111, 6'b001000, 4'b1000};
        vec[13] = {3'b111, 6'b111111, 4'b1001};
        vec[14] = {3'b111, 6'b010000, 4'b1100};
        vec[15] = {3'b111, 6'b010010, 4'b1101};
        vec[16] = {3'b101, 6'b100000, 4'b1001};
        for (int i = 0; i < 17; i++) begin
            e = vec[i];
            drive(1'b1, e[12:10], e[9:4]);
            @(negedge clk);
            check("decode", int'(bus.ALUOperation), int'(e[3:0]));
            check("decode_stall", int'(bus.Stall), 0);
            next_cycle();
        end

        // Valid=0 with MULT funct: no start
        drive(1'b0, 3'b111, 6'b011000);
        @(negedge clk);
        check("novalid_op", int'(bus.ALUOperation), 9);
        check("novalid_start", int'(bus.MDStart), 0);
        next_cycle();
        @(negedge clk);
        check("novalid_busy", int'(bus.Busy), 0);
        next_cycle();

        // MULT
        run_md(6'b011000, st, sp, sl, hw, sc, hc, sg, dv);
        check("mult_starts", st, 1);
        check("mult_start_cyc", sc, 0);
        check("mult_steps", sp, 32);
        check("mult_stall", sl, 33);
        check("mult_hilo_cyc", hc, 33);
        check("mult_signed", int'(sg), 1);
        check("mult_div", int'(dv), 0);

        // DIVU followed by idle bus
        run_md(6'b011011, st, sp, sl, hw, sc, hc, sg, dv);
        check("divu_starts", st, 1);
        check("divu_hilos", hw, 1);
        drive(1'b0, 3'b000, 6'b000000);
        @(negedge clk);
        check("divu_idle34", int'(bus.Busy), 0);
        check("divu_signed", int'(bus.MDSigned), 0);
        check("divu_div", int'(bus.MDDiv), 1);
        next_cycle();

        // Back-to-back MULTU then DIV
        run_md(6'b011001, st, sp, sl, hw, sc, hc, sg, dv);
        check("b2b1_steps", sp, 32);
        check("b2b1_signed", int'(sg), 0);
        run_md(6'b011010, st, sp, sl, hw, sc, hc, sg, dv);
        check("b2b2_start_cyc", sc, 0);
        check("b2b2_steps", sp, 32);
        check("b2b2_hilo_cyc", hc, 33);
        check("b2b2_signed", int'(sg), 1);
        check("b2b2_div", int'(dv), 1);
        drive(1'b0, 3'b000, 6'b000000);
        next_cycle();

        // Reset low at RUN step 10
        drive(1'b1, 3'b111, 6'b011000);
        for (int c = 0; c < 10; c++) next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 3'b000, 6'b000000);
        @(negedge clk);
        check("rstmid_busy", int'(bus.Busy), 0);
        check("rstmid_step", int'(bus.MDStep), 0);
        check("rstmid_stall", int'(bus.Stall), 0);
        check("rstmid_signed", int'(bus.MDSigned), 0);
        hw = 0;
        for (int c = 0; c < DW + 4; c++) begin
            next_cycle();
            @(negedge clk);
            if (bus.HILOWrite) hw++;
        end
        check("rstmid_no_hilo", hw, 0);
        next_cycle();

        // MFLO
        drive(1'b1, 3'b111, 6'b010010);
        @(negedge clk);
        check("mflo_op", int'(bus.ALUOperation), 13);
        check("mflo_stall", int'(bus.Stall), 0);
        next_cycle();

        // Randomized stimulus; per-cycle model compare does the checking
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] f;
            logic [2:0] op;
            op = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom);
            case ($urandom_range(0, 3))
                0: f = 6'b011000 | 6'($urandom_range(0, 3));
                1: f = 6'($urandom);
                2: f = ($urandom_range(0, 1) == 0) ? 6'b010000 : 6'b010010;
                default: f = 6'b100000 | 6'($urandom_range(0, 7));
            endcase
            drive($urandom_range(0, 7) != 0, op, f);
            reset = ($urandom_range(0, 59) != 0);
            next_cycle();
        end
        reset = 1'b1;
        drive(1'b0, 3'b000, 6'b000000);
        repeat (DW + 3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
